// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the single-cycle controller/datapath. Owns the PC,
//   issues in-order word requests to instruction memory, buffers in-order
//   responses in a small prefetch queue and hands {instr, instr_pc} downstream
//   under valid/ready. A redirect flushes queued and in-flight instructions
//   and restarts fetch at a new word address.
//
//   Parameters: RESET_PC (PC after reset), DEPTH (queue entries, 2/4/8; also
//   the cap on in-flight plus buffered instructions).
//   Ports:
//     clk, reset                       clock, async active-high reset
//     imem_req_valid/addr/ready        request channel (addr = current PC)
//     imem_rsp_valid/data              in-order response words
//     redirect, redirect_pc            flush + restart address (bits [1:0] dropped)
//     instr, instr_pc, instr_valid     queue head to the downstream stage
//     instr_ready                      downstream consumes the head this cycle
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {START, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] q_head, q_tail;
  logic [AW-1:0] t_head, t_tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   tag     [DEPTH];

  logic          pop, accept, rsp_ok, push;
  logic [CW:0]   inuse;
  logic [CW-1:0] out_next;

  assign instr_valid   = (count != '0);
  assign instr         = q_instr[q_head];
  assign instr_pc      = q_pc[q_head];
  assign imem_req_addr = pc;

  assign pop    = instr_valid & instr_ready;
  assign accept = imem_req_valid & imem_req_ready;
  // Responses with nothing outstanding belong to requests issued before a
  // reset; they are ignored so they can never be paired with a fresh tag.
  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  assign push   = rsp_ok & (drop_cnt == '0);

  assign inuse    = {1'b0, count} + {1'b0, outstanding};
  assign out_next = outstanding + CW'(accept) - CW'(rsp_ok);

  // A pop this cycle frees a slot, so a request may still go out at the cap.
  assign imem_req_valid = (state == RUN) && !redirect &&
                          ((inuse < CAP) || ((inuse == CAP) && pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      t_head      <= '0;
      t_tail      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        tag[i]     <= '0;
      end
    end else begin
      outstanding <= out_next;

      // The tag FIFO keeps running through a redirect: discarded responses
      // still have to retire their tags in order.
      if (accept) begin
        tag[t_tail] <= pc;
        t_tail      <= t_tail + 1'b1;
        pc          <= pc + 32'd4;
      end
      if (rsp_ok) begin
        t_head <= t_head + 1'b1;
      end

      if (redirect) begin
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        pc       <= redirect_pc & ~32'h3;
        drop_cnt <= out_next;
        state    <= (out_next != '0) ? DRAIN : RUN;
      end else begin
        if (push) begin
          q_instr[q_tail] <= imem_rsp_data;
          q_pc[q_tail]    <= tag[t_head];
          q_tail          <= q_tail + 1'b1;
        end
        if (pop) begin
          q_head <= q_head + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);

        if (rsp_ok && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end

        case (state)
          START:   state <= RUN;
          DRAIN:   if ((drop_cnt == '0) || (rsp_ok && (drop_cnt == CW'(1)))) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] MAIN_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH   = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instr_fetch_unit #(.RESET_PC(MAIN_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  // Second instance started near the top of the address space.
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_instr, w_instr_pc;
  logic        w_instr_valid;
  logic        w_acc;
  logic [31:0] w_addrs[$];

  instr_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(32'h0),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .instr_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    w_acc       = 1'b0;
    w_rsp_valid = 1'b0;
  end
  always @(negedge clk) begin
    w_acc = w_req_valid && !reset;
    if (w_acc) w_addrs.push_back(w_req_addr);
  end
  always @(posedge clk) w_rsp_valid <= w_acc;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
    bit          orphan;
  } req_t;
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  req_t        pend[$];   // requests accepted by memory, oldest first
  ent_t        mq[$];     // instructions the fetch unit should be holding
  int          cyc;
  bit          start;
  int          stale_cnt;
  logic [31:0] exp_req_pc;
  int          lat_min, lat_max;
  bit          jitter;
  bit          rsp_now;

  int checks;
  int errors;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int inflight();
    int n = 0;
    for (int i = 0; i < pend.size(); i++) if (!pend[i].orphan) n++;
    return n;
  endfunction

  // One clock cycle: memory drives its response, outputs are compared with
  // the model, then the model advances on the rising edge.
  task automatic cycle();
    logic        exp_rv, exp_iv, pop;
    logic [31:0] exp_addr;
    int          n, l;
    req_t        r;
    ent_t        e;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc) &&
              (pend[0].orphan || !jitter || ($urandom_range(3) != 0));
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word_of(pend[0].addr) : $urandom;
    #1;
    n        = inflight();
    pop      = !reset && (mq.size() != 0) && instr_ready;
    exp_iv   = !reset && (mq.size() != 0);
    exp_rv   = !reset && !start && (stale_cnt == 0) && !redirect &&
               (((mq.size() + n) < DEPTH) || (((mq.size() + n) == DEPTH) && pop));
    exp_addr = reset ? MAIN_PC : exp_req_pc;

    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc %0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
    end
    checks++;
    if (imem_req_addr !== exp_addr) begin
      errors++;
      $display("FAIL req_addr cyc %0d: got %h expected %h", cyc, imem_req_addr, exp_addr);
    end
    checks++;
    if (instr_valid !== exp_iv) begin
      errors++;
      $display("FAIL instr_valid cyc %0d: got %b expected %b", cyc, instr_valid, exp_iv);
    end
    if (reset) begin
      checks++;
      if (instr !== 32'h0 || instr_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_instr cyc %0d: got %h/%h expected 0/0", cyc, instr, instr_pc);
      end
    end else if (exp_iv) begin
      e = mq[0];
      checks++;
      if (instr !== e.data || instr_pc !== e.pc) begin
        errors++;
        $display("FAIL instr cyc %0d: got %h@%h expected %h@%h", cyc, instr, instr_pc, e.data, e.pc);
      end
    end

    @(posedge clk);
    if (rsp_now) r = pend.pop_front();
    if (reset) begin
      mq.delete();
      for (int i = 0; i < pend.size(); i++) begin
        req_t t = pend[i];
        t.orphan = 1'b1;
        t.due    = 0;
        pend[i]  = t;
      end
      stale_cnt  = 0;
      start      = 1'b1;
      exp_req_pc = MAIN_PC;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rsp_now && !r.orphan) begin
        if (r.stale) stale_cnt--;
        else if (!redirect) begin
          e.data = word_of(r.addr);
          e.pc   = r.addr;
          mq.push_back(e);
        end
      end
      if (exp_rv && imem_req_ready) begin
        l        = $urandom_range(lat_max, lat_min);
        r.addr   = exp_req_pc;
        r.due    = cyc + 1 + (l - 1) + 0;
        r.due    = cyc + l;
        r.stale  = 1'b0;
        r.orphan = 1'b0;
        pend.push_back(r);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redirect) begin
        mq.delete();
        for (int i = 0; i < pend.size(); i++) begin
          req_t t = pend[i];
          if (!t.orphan && !t.stale) begin
            t.stale = 1'b1;
            stale_cnt++;
          end
          pend[i] = t;
        end
        exp_req_pc = redirect_pc & ~32'h3;
      end
      start = 1'b0;
    end
    cyc++;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first = -1;
    reset = 1'b1;
    cycle();
    cycle();
    reset       = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (instr_valid && first < 0) first = k + 1;
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d expected 3", first);
    end
  endtask

  task automatic test_throughput();
    int pops = 0;
    instr_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) pops++;
      cycle();
    end
    checks++;
    if (pops != 20) begin
      errors++;
      $display("FAIL throughput: got %0d pops expected 20", pops);
    end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_stall: got req_valid %b instr_valid %b expected 0 1",
               imem_req_valid, instr_valid);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) pops++;
      cycle();
    end
    checks++;
    if (pops != 20) begin
      errors++;
      $display("FAIL backpressure_resume: got %0d pops expected 20", pops);
    end
  endtask

  task automatic test_redirect_drain();
    bit found = 1'b0;
    int drain = 0;
    bit got   = 1'b0;
    lat_min = 3; lat_max = 3;
    instr_ready = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      if (inflight() == 2 && pend[0].due > cyc) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drain_setup: got no two-in-flight cycle expected one within 30");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_req_valid) begin
        found = 1'b1;
        checks++;
        if (imem_req_addr !== 32'h0000_0100) begin
          errors++;
          $display("FAIL drain_first_addr: got %h expected 00000100", imem_req_addr);
        end
      end else begin
        drain++;
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL drain_instr_valid: got %b expected 0", instr_valid);
        end
        cycle();
      end
    end
    checks++;
    if (!found || drain < 2) begin
      errors++;
      $display("FAIL drain_length: got %0d cycles (restart %b) expected >=2 and restart 1",
               drain, found);
    end
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      if (instr_valid) begin
        got = 1'b1;
        checks++;
        if (instr_pc !== 32'h0000_0100) begin
          errors++;
          $display("FAIL drain_first_pc: got %h expected 00000100", instr_pc);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL drain_restart_timeout: got no instr_valid expected one within 10 cycles");
    end
  endtask

  task automatic test_redirect_collide();
    bit found = 1'b0;
    bit got   = 1'b0;
    lat_min = 2; lat_max = 2;
    instr_ready = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && !pend[0].stale && !pend[0].orphan &&
          stale_cnt == 0)
        found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL collide_setup: got no response cycle expected one within 30");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    cycle();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_flush: got instr_valid %b expected 0", instr_valid);
    end
    for (int k = 0; k < 15; k++) begin
      if (instr_valid && !got) begin
        got = 1'b1;
        checks++;
        if (instr_pc !== 32'h0000_2000) begin
          errors++;
          $display("FAIL collide_first_pc: got %h expected 00002000", instr_pc);
        end
      end
      cycle();
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; jitter = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      instr_ready    = ($urandom_range(3) != 0);
      imem_req_ready = ($urandom_range(3) != 0);
      redirect       = !start && ($urandom_range(24) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1; jitter = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit found = 1'b0;
    bit seen  = 1'b0;
    lat_min = 3; lat_max = 3;
    instr_ready = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      if (inflight() == 2) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_setup: got no two-in-flight cycle expected one within 30");
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_valid %0d: got %b expected 0", k, instr_valid);
      end
      if (imem_req_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if (imem_req_addr !== MAIN_PC) begin
          errors++;
          $display("FAIL midreset_addr: got %h expected %h", imem_req_addr, MAIN_PC);
        end
      end
      cycle();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midreset_restart: got no request expected one within 4 cycles");
    end
    for (int k = 0; k < 20; k++) cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF_FFF8;
    exp_w[1] = 32'hFFFF_FFFC;
    exp_w[2] = 32'h0000_0000;
    checks++;
    if (w_addrs.size() < 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d requests expected >=3", w_addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (w_addrs[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL wrap_addr %0d: got %h expected %h", i, w_addrs[i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    cyc = 0; start = 1'b1; stale_cnt = 0; exp_req_pc = MAIN_PC;
    lat_min = 1; lat_max = 1; jitter = 1'b0;
    reset = 1'b1; instr_ready = 1'b0; imem_req_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    #1;
    test_reset();
    test_throughput();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collide();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
